// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART command processor.
// The opcode set, parser states and the accumulate step used by the packet FSM.
package uart_alu_pkg;

  localparam int HEADER_BYTES = 4;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'hAD;
  localparam logic [7:0] OP_MUL32 = 8'h88;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RSV,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_RESULT
  } state_e;

  // Folds one 32-bit operand into the running result; only the low 32 bits are kept.
  function automatic logic [31:0] alu_apply(input logic [7:0]  op,
                                            input logic [31:0] acc,
                                            input logic [31:0] operand);
    return (op == OP_MUL32) ? acc * operand : acc + operand;
  endfunction

endpackage

// File: rtl/uart_alu_if.sv
// Byte-wide AXI-stream link between the UART cores and the packet FSM.
// tuser marks a character received with a bad stop bit.
interface uart_alu_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);

endinterface

// File: rtl/alu_packet_fsm.sv
// Packet parser: header decode, echo through a one-byte holding register,
// and a 32-bit add/multiply accumulator returned as four little-endian bytes.
module alu_packet_fsm
  import uart_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  uart_alu_if.slave  rx_axis,
  uart_alu_if.master tx_axis
);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remain_q, remain_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  res_idx_q, res_idx_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic        rx_ready, rx_good, is_alu;
  logic [15:0] len_w;
  logic [31:0] word_w;
  logic [7:0]  res_byte;

  // Stall the receiver while the result drains, or while the holding register cannot empty.
  assign rx_ready       = (state_q != ST_RESULT) && (!out_valid_q || tx_axis.tready);
  assign rx_axis.tready = rx_ready;
  assign rx_good        = rx_axis.tvalid && rx_ready && !rx_axis.tuser;
  assign is_alu         = (opcode_q == OP_ADD32) || (opcode_q == OP_MUL32);

  assign tx_axis.tdata  = out_data_q;
  assign tx_axis.tvalid = out_valid_q;
  assign tx_axis.tuser  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      len_lo_q    <= '0;
      remain_q    <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      acc_q       <= '0;
      res_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      len_lo_q    <= len_lo_d;
      remain_q    <= remain_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      res_idx_q   <= res_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value starts from its register so no branch can infer a latch.
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_lo_d    = len_lo_q;
    remain_d    = remain_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    res_idx_d   = res_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    len_w    = {rx_axis.tdata, len_lo_q};
    word_w   = word_q | (32'(rx_axis.tdata) << {byte_idx_q, 3'b000});
    res_byte = 8'(acc_q >> {res_idx_q, 3'b000});

    if (out_valid_q && tx_axis.tready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_good) begin
          opcode_d   = rx_axis.tdata;
          acc_d      = (rx_axis.tdata == OP_MUL32) ? 32'd1 : 32'd0;
          word_d     = '0;
          byte_idx_d = '0;
          state_d    = ST_RSV;
        end
      end
      ST_RSV: begin
        if (rx_good) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_good) begin
          len_lo_d = rx_axis.tdata;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_good) begin
          res_idx_d = '0;
          if (len_w <= 16'(HEADER_BYTES)) begin
            state_d = is_alu ? ST_RESULT : ST_IDLE;
          end else begin
            remain_d = len_w - 16'(HEADER_BYTES);
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_good) begin
          remain_d = remain_q - 1'b1;
          if (opcode_q == OP_ECHO) begin
            out_data_d  = rx_axis.tdata;
            out_valid_d = 1'b1;
          end
          // A short final operand is applied as-is, i.e. zero-extended in its high bytes.
          if (byte_idx_q == 2'd3 || remain_q == 16'd1) begin
            acc_d      = alu_apply(opcode_q, acc_q, word_w);
            word_d     = '0;
            byte_idx_d = '0;
          end else begin
            word_d     = word_w;
            byte_idx_d = byte_idx_q + 1'b1;
          end
          if (remain_q == 16'd1) begin
            res_idx_d = '0;
            state_d   = is_alu ? ST_RESULT : ST_IDLE;
          end
        end
      end
      ST_RESULT: begin
        if (!out_valid_q || tx_axis.tready) begin
          out_data_d  = res_byte;
          out_valid_d = 1'b1;
          res_idx_d   = res_idx_q + 1'b1;
          if (res_idx_q == 2'd3) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an AXI-stream byte output; bit period is 8*PRESCALE clocks.
// A character whose stop bit reads low is still delivered, flagged on tuser.
module uart_rx #(
  parameter int PRESCALE   = 33,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  uart_alu_if.master m_axis
);

  localparam int BIT_CYCLES = 8 * PRESCALE;
  localparam int TW         = $clog2(BIT_CYCLES);
  localparam int CW         = $clog2(DATA_WIDTH + 3);

  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FRAME_BITS = CW'(DATA_WIDTH + 2);
  localparam logic [CW-1:0] STOP_BIT   = CW'(1);

  logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic                  busy_q;
  logic [TW-1:0]         timer_q;
  logic [CW-1:0]         bits_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ferr_q;

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tuser  = ferr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      busy_q     <= 1'b0;
      timer_q    <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;

      if (valid_q && m_axis.tready) valid_q <= 1'b0;

      // Arm only on a falling edge so a line held low after a framing error is not a start bit.
      if (!busy_q) begin
        if (rxd_prev_q && !rxd_sync_q) begin
          busy_q  <= 1'b1;
          timer_q <= HALF_LAST;
          bits_q  <= FRAME_BITS;
        end
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end else begin
        timer_q <= BIT_LAST;
        if (bits_q == FRAME_BITS) begin
          if (rxd_sync_q) busy_q <= 1'b0;
          else            bits_q <= bits_q - 1'b1;
        end else if (bits_q == STOP_BIT) begin
          busy_q  <= 1'b0;
          data_q  <= shift_q;
          valid_q <= 1'b1;
          ferr_q  <= !rxd_sync_q;
        end else begin
          shift_q <= {rxd_sync_q, shift_q[DATA_WIDTH-1:1]};
          bits_q  <= bits_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an AXI-stream byte input; bit period is 8*PRESCALE clocks.
// tready is high only while the line is idle, so one character is in flight at a time.
module uart_tx #(
  parameter int PRESCALE   = 33,
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_alu_if.slave s_axis,
  output logic      txd
);

  localparam int BIT_CYCLES = 8 * PRESCALE;
  localparam int TW         = $clog2(BIT_CYCLES);
  localparam int CW         = $clog2(DATA_WIDTH + 2);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LEN = CW'(DATA_WIDTH + 1);

  logic                busy_q;
  logic [TW-1:0]       timer_q;
  logic [CW-1:0]       bits_q;
  logic [DATA_WIDTH:0] shift_q;
  logic                txd_q;

  assign s_axis.tready = !busy_q;
  assign txd           = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      timer_q <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else if (!busy_q) begin
      if (s_axis.tvalid) begin
        busy_q  <= 1'b1;
        txd_q   <= 1'b0;
        shift_q <= {1'b1, s_axis.tdata};
        bits_q  <= SHIFT_LEN;
        timer_q <= BIT_LAST;
      end
    end else if (timer_q != '0) begin
      timer_q <= timer_q - 1'b1;
    end else if (bits_q == '0) begin
      busy_q <= 1'b0;
    end else begin
      // Data bits then the stop bit shift out of the low end; the line is left high.
      txd_q   <= shift_q[0];
      shift_q <= {1'b1, shift_q[DATA_WIDTH:1]};
      bits_q  <= bits_q - 1'b1;
      timer_q <= BIT_LAST;
    end
  end

endmodule

// File: rtl/uart_alu_top.sv
// Board-level UART command processor: uart_rx -> packet FSM -> uart_tx,
// all in the single PLL clock domain.
module uart_alu_top #(
  parameter int PRESCALE   = 33,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd
);

  uart_alu_if #(.DATA_WIDTH(DATA_WIDTH)) rx_axis ();
  uart_alu_if #(.DATA_WIDTH(DATA_WIDTH)) tx_axis ();

  uart_rx #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rx (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .m_axis(rx_axis)
  );

  alu_packet_fsm u_fsm (
    .clk    (clk),
    .rst    (rst),
    .rx_axis(rx_axis),
    .tx_axis(tx_axis)
  );

  uart_tx #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .s_axis(tx_axis),
    .txd   (txd)
  );

endmodule

// File: tb/tb_uart_alu_top.sv
// Serial-level bench for uart_alu_top: drives packets on rxd, decodes txd,
// and compares each decoded byte against a queue filled from a packet model.
module tb_uart_alu_top;
  import uart_alu_pkg::*;

  localparam int PRESCALE   = 4;
  localparam int BIT        = 8 * PRESCALE;
  localparam int DRAIN_MAX  = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  uart_alu_if #(.DATA_WIDTH(8)) mon_if ();

  uart_alu_top #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .txd(txd)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       mon_abort;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected response of one packet; bad_idx names a byte sent with a broken stop bit.
  function automatic void model(input logic [7:0] pkt[$], input int bad_idx);
    logic [7:0]  g[$];
    int          n;
    logic [31:0] acc, w;
    foreach (pkt[i]) if (i != bad_idx) g.push_back(pkt[i]);
    n = int'({g[3], g[2]}) - HEADER_BYTES;
    if (n < 0) n = 0;
    if (g[0] == OP_ECHO) begin
      for (int i = 0; i < n; i++) exp_q.push_back(g[4+i]);
    end else if (g[0] == OP_ADD32 || g[0] == OP_MUL32) begin
      acc = (g[0] == OP_MUL32) ? 32'd1 : 32'd0;
      for (int k = 0; k < n; k += 4) begin
        w = '0;
        for (int j = 0; j < 4 && k + j < n; j++) w[8*j +: 8] = g[4+k+j];
        acc = (g[0] == OP_MUL32) ? acc * w : acc + w;
      end
      for (int j = 0; j < 4; j++) exp_q.push_back(acc[8*j +: 8]);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = !bad_stop;
    repeat (BIT) @(negedge clk);
    if (bad_stop) begin
      rxd = 1'b1;
      repeat (2 * BIT) @(negedge clk);
    end
  endtask

  task automatic run_packet(input logic [7:0] pkt[$], input int bad_idx);
    model(pkt, bad_idx);
    foreach (pkt[i]) send_byte(pkt[i], i == bad_idx);
  endtask

  task automatic send_raw(input logic [7:0] pkt[$]);
    foreach (pkt[i]) send_byte(pkt[i], 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int cycles = 0;
    while (exp_q.size() != 0 && cycles < DRAIN_MAX) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (BIT) @(negedge clk);
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) mon_abort = 1'b1;
    end
    #1;
  endtask

  // txd decoder: frames overlapped by a reset pulse are discarded.
  initial begin
    mon_if.tdata  = '0;
    mon_if.tvalid = 1'b0;
    mon_if.tready = 1'b1;
    mon_if.tuser  = 1'b0;
    forever begin
      logic [7:0] b;
      logic       stop_bit;
      @(negedge txd);
      mon_abort = rst;
      mon_wait(BIT / 2);
      if (txd) continue;
      for (int i = 0; i < 8; i++) begin
        mon_wait(BIT);
        b[i] = txd;
      end
      mon_wait(BIT);
      stop_bit = txd;
      if (mon_abort) continue;
      mon_if.tdata  = b;
      mon_if.tuser  = !stop_bit;
      mon_if.tvalid = 1'b1;
      check("tx_stop_bit", 32'(mon_if.tuser), 32'd0);
      if (exp_q.size() == 0) check("tx_spurious", 32'(mon_if.tdata), 32'h100);
      else                   check("tx_byte", 32'(mon_if.tdata), 32'(exp_q.pop_front()));
      mon_if.tvalid = 1'b0;
    end
  end

  initial begin
    logic [7:0] pkt[$];
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("txd_in_reset", 32'(txd), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    check("txd_idle", 32'(txd), 32'd1);

    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    run_packet(pkt, -1);
    wait_drain("echo");

    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, -1);
    wait_drain("add");

    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, -1);
    wait_drain("add_wrap");

    pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet(pkt, -1);
    wait_drain("mul");

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    run_packet(pkt, -1);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    run_packet(pkt, -1);
    wait_drain("unknown_then_echo");

    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    run_packet(pkt, -1);
    wait_drain("add_zero_ops");

    pkt = '{8'h88, 8'h00, 8'h04, 8'h00};
    run_packet(pkt, -1);
    wait_drain("mul_zero_ops");

    pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h05, 8'h01, 8'h02};
    run_packet(pkt, -1);
    wait_drain("add_partial");

    pkt = '{8'h88, 8'h00, 8'h0A, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01};
    run_packet(pkt, -1);
    wait_drain("mul_partial");

    pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
    run_packet(pkt, -1);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    run_packet(pkt, -1);
    wait_drain("short_len");

    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22, 8'h33};
    run_packet(pkt, 5);
    wait_drain("frame_error");

    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h01};
    send_raw(pkt);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("txd_mid_reset", 32'(txd), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("txd_after_reset", 32'(txd), 32'd1);
    repeat (BIT) @(negedge clk);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    run_packet(pkt, -1);
    wait_drain("reset_mid_packet");

    repeat (20 * BIT) @(negedge clk);
    check("txd_final_idle", 32'(txd), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
